// File: rtl/async_fifo_pkg.sv
// Shared async FIFO helpers: Gray/binary conversion and pointer-width convention.
// Conversions work on a zero-extended PTR_MAXW-bit value, so any width up to PTR_MAXW is served.
package async_fifo_pkg;

    localparam int unsigned PTR_MAXW         = 32;
    localparam int unsigned ADDRSIZE_DEFAULT = 4;
    // Pointers carry one extra MSB to tell full from empty.
    localparam int unsigned PTRW_DEFAULT     = ADDRSIZE_DEFAULT + 1;

    function automatic logic [PTR_MAXW-1:0] bin2gray(input logic [PTR_MAXW-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    // Prefix XOR from the MSB down; zero upper bits leave the result unaffected.
    function automatic logic [PTR_MAXW-1:0] gray2bin(input logic [PTR_MAXW-1:0] gray);
        logic [PTR_MAXW-1:0] bin;
        bin = gray;
        bin = bin ^ (bin >> 1);
        bin = bin ^ (bin >> 2);
        bin = bin ^ (bin >> 4);
        bin = bin ^ (bin >> 8);
        bin = bin ^ (bin >> 16);
        return bin;
    endfunction

endpackage

// File: rtl/gray2bin.sv
// Width-parameterised Gray-to-binary converter, shared by the read and write pointer blocks.
module gray2bin #(
    parameter int unsigned WIDTH = 5
) (
    input  logic [WIDTH-1:0] gray_i,
    output logic [WIDTH-1:0] bin_o
);

    localparam int unsigned MAXW = async_fifo_pkg::PTR_MAXW;

    assign bin_o = WIDTH'(async_fifo_pkg::gray2bin(MAXW'(gray_i)));

endmodule

// File: rtl/rptr_empty_lvl.sv
// Read-side pointer, empty/almost-empty and fill-level block for the async FIFO.
// Optional sticky underflow detection: define RPTR_EMPTY_LVL_UNDERFLOW_EN.
module rptr_empty_lvl
    import async_fifo_pkg::*;
#(
    parameter int unsigned ADDRSIZE = 4
) (
    input  logic                rclk,
    input  logic                rrst,
    input  logic                rinc,
    input  logic [ADDRSIZE:0]   rq2_wptr,
    input  logic [ADDRSIZE:0]   rthresh,
    output logic                rpop,
    output logic [ADDRSIZE-1:0] raddr,
    output logic [ADDRSIZE:0]   rptr,
    output logic                rempty,
    output logic                arempty,
    output logic [ADDRSIZE:0]   rlevel,
    output logic                runderflow
);

    localparam int unsigned PTRW = ADDRSIZE + 1;

    logic [PTRW-1:0] rbin_q, rbin_d;
    logic [PTRW-1:0] rptr_q, rptr_d;
    logic [PTRW-1:0] rlevel_q, rlevel_d;
    logic            rempty_q, rempty_d;
    logic            arempty_q, arempty_d;
    logic [PTRW-1:0] wbin;

    gray2bin #(.WIDTH(PTRW)) u_wptr_g2b (
        .gray_i (rq2_wptr),
        .bin_o  (wbin)
    );

    // Next pointer and status; level wraps modulo 2^PTRW with no saturation.
    always_comb begin
        rpop      = rinc & ~rempty_q;
        rbin_d    = rbin_q + PTRW'(rpop);
        rptr_d    = PTRW'(bin2gray(PTR_MAXW'(rbin_d)));
        rlevel_d  = wbin - rbin_d;
        rempty_d  = (rptr_d == rq2_wptr);
        arempty_d = (rlevel_d <= rthresh);
    end

    always_ff @(posedge rclk) begin
        if (rrst) begin
            rbin_q    <= '0;
            rptr_q    <= '0;
            rlevel_q  <= '0;
            rempty_q  <= 1'b1;
            arempty_q <= 1'b1;
        end else begin
            rbin_q    <= rbin_d;
            rptr_q    <= rptr_d;
            rlevel_q  <= rlevel_d;
            rempty_q  <= rempty_d;
            arempty_q <= arempty_d;
        end
    end

`ifdef RPTR_EMPTY_LVL_UNDERFLOW_EN
    logic runderflow_q;

    // Sticky until reset once a pop is attempted on an empty FIFO.
    always_ff @(posedge rclk) begin
        if (rrst) begin
            runderflow_q <= 1'b0;
        end else if (rinc & rempty_q) begin
            runderflow_q <= 1'b1;
        end
    end

    assign runderflow = runderflow_q;
`else
    assign runderflow = 1'b0;
`endif

    assign raddr   = rbin_q[ADDRSIZE-1:0];
    assign rptr    = rptr_q;
    assign rempty  = rempty_q;
    assign arempty = arempty_q;
    assign rlevel  = rlevel_q;

endmodule

// File: tb/tb_rptr_empty_lvl.sv
// Scoreboard bench for rptr_empty_lvl: driver pushes expected outputs, negedge monitor compares.
module tb_rptr_empty_lvl;

    localparam int unsigned ADDRSIZE = 4;
    localparam int unsigned PTRW     = ADDRSIZE + 1;
    localparam int          MOD      = 1 << PTRW;
    localparam int          DEPTH    = 1 << ADDRSIZE;

    logic                rclk = 1'b0;
    logic                rrst = 1'b0;
    logic                rinc = 1'b0;
    logic [ADDRSIZE:0]   rq2_wptr = '0;
    logic [ADDRSIZE:0]   rthresh = '0;
    logic                rpop;
    logic [ADDRSIZE-1:0] raddr;
    logic [ADDRSIZE:0]   rptr;
    logic                rempty;
    logic                arempty;
    logic [ADDRSIZE:0]   rlevel;
    logic                runderflow;

    rptr_empty_lvl #(.ADDRSIZE(ADDRSIZE)) dut (
        .rclk       (rclk),
        .rrst       (rrst),
        .rinc       (rinc),
        .rq2_wptr   (rq2_wptr),
        .rthresh    (rthresh),
        .rpop       (rpop),
        .raddr      (raddr),
        .rptr       (rptr),
        .rempty     (rempty),
        .arempty    (arempty),
        .rlevel     (rlevel),
        .runderflow (runderflow)
    );

    always #5 rclk = ~rclk;

    typedef struct {
        bit valid;
        int rpop;
        int raddr;
        int rptr;
        int rempty;
        int arempty;
        int rlevel;
        int uf;
    } exp_t;

    exp_t exp_q[$];
    int total = 0;
    int bad   = 0;

    // Reference model: counts of reads and writes, everything else derived arithmetically.
    bit m_valid = 0;
    int m_rd    = 0;
    int m_wr    = 0;
    int m_empty = 1;
    int m_ae    = 1;
    int m_level = 0;
    int m_uf    = 0;

    function automatic int gray_of(input int v);
        return (v ^ (v >> 1)) % MOD;
    endfunction

    task automatic chk(input string name, input int act, input int expv);
        total++;
        if (act != expv) begin
            bad++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, expv);
        end
    endtask

    // One cycle: drive inputs, queue the outputs the DUT should show this cycle, then advance the model.
    task automatic step(input bit rst, input bit inc, input int wr, input int th);
        exp_t e;
        int   pop;
        @(posedge rclk);
        #1;
        rrst     = rst;
        rinc     = inc;
        rq2_wptr = PTRW'(gray_of(wr));
        rthresh  = PTRW'(th);
        m_wr     = wr;
        e.valid   = m_valid;
        e.rpop    = (inc && !m_empty) ? 1 : 0;
        e.raddr   = m_rd % DEPTH;
        e.rptr    = gray_of(m_rd);
        e.rempty  = m_empty;
        e.arempty = m_ae;
        e.rlevel  = m_level;
        e.uf      = m_uf;
        exp_q.push_back(e);
        if (rst) begin
            m_rd = 0; m_empty = 1; m_ae = 1; m_level = 0; m_uf = 0;
            m_valid = 1;
        end else if (m_valid) begin
`ifdef RPTR_EMPTY_LVL_UNDERFLOW_EN
            if (inc && m_empty) m_uf = 1;
`endif
            pop     = (inc && !m_empty) ? 1 : 0;
            m_rd    = (m_rd + pop) % MOD;
            m_level = ((m_wr - m_rd) % MOD + MOD) % MOD;
            m_empty = (m_level == 0) ? 1 : 0;
            m_ae    = (m_level <= th) ? 1 : 0;
        end
    endtask

    // Monitor: outputs are presented every cycle; compare away from the active edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge rclk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                if (e.valid) begin
                    chk("rpop",       int'(rpop),       e.rpop);
                    chk("raddr",      int'(raddr),      e.raddr);
                    chk("rptr",       int'(rptr),       e.rptr);
                    chk("rempty",     int'(rempty),     e.rempty);
                    chk("arempty",    int'(arempty),    e.arempty);
                    chk("rlevel",     int'(rlevel),     e.rlevel);
                    chk("runderflow", int'(runderflow), e.uf);
                end
            end
        end
    end

    initial begin
        int w;
        int th;
        bit inc;
        // Reset with pop requested.
        step(1, 1, 0, 0);
        step(1, 1, 0, 0);
        // Basic drain of three entries, threshold 1.
        step(0, 0, 3, 1);
        step(0, 1, 3, 1);
        step(0, 1, 3, 1);
        step(0, 1, 3, 1);
        step(0, 0, 3, 1);
        // Underflow attempts then release.
        step(0, 1, 3, 1);
        step(0, 1, 3, 1);
        step(0, 0, 3, 1);
        step(0, 0, 3, 1);
        // Walk the read pointer to 15, then expose two entries across the wrap.
        step(0, 0, 15, 1);
        for (int i = 0; i < 12; i++) step(0, 1, 15, 1);
        step(0, 0, 17, 1);
        step(0, 1, 17, 1);
        step(0, 1, 17, 1);
        step(0, 0, 17, 1);
        // Simultaneous pop and write advance at level 2.
        step(0, 0, 19, 1);
        step(0, 1, 20, 1);
        step(0, 0, 20, 1);
        // Reset mid-operation at level 5.
        step(0, 0, 23, 1);
        step(1, 1, 0, 1);
        step(0, 0, 0, 1);

        // Randomised traffic respecting FIFO depth.
        w  = 0;
        th = 2;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                w = 0;
                step(1, 1'($urandom_range(0, 1)), 0, th);
            end else begin
                if ((i % 64) == 0) th = int'($urandom_range(0, MOD - 1));
                if ($urandom_range(0, 9) < 4 && (((w - m_rd) % MOD + MOD) % MOD) < DEPTH)
                    w = (w + 1) % MOD;
                inc = 1'($urandom_range(0, 1));
                step(0, inc, w, th);
            end
        end
        step(0, 0, w, th);
        @(negedge rclk);
        @(negedge rclk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rptr_empty_lvl.md
# rptr_empty_lvl

Read-side pointer and status block for the async FIFO, replacing the plain empty/almost-empty generator. It runs in the read clock domain and advances a binary/Gray read pointer on accepted pops. It converts the already-synchronised Gray write pointer to binary, and from that produces registered empty, threshold-programmable almost-empty and fill-level outputs. It also flags reads attempted on an empty FIFO as underflow.

## Interface
- ADDRSIZE, 4, FIFO depth is 2^ADDRSIZE; pointers are ADDRSIZE+1 bits wide.
- rclk  in  1  read-domain clock.
- rrst  in  1  reset; synchronous, active-high.
- rinc  in  1  pop request.
- rq2_wptr  in  ADDRSIZE+1  Gray write pointer, already double-synchronised into rclk.
- rthresh  in  ADDRSIZE+1  almost-empty threshold in entries; quasi-static.
- rpop  out  1  accepted pop; combinational, equals rinc & ~rempty.
- raddr  out  ADDRSIZE  binary memory read address, registered.
- rptr  out  ADDRSIZE+1  Gray read pointer, registered, sent to the write domain.
- rempty  out  1  FIFO empty, registered.
- arempty  out  1  almost empty, registered.
- rlevel  out  ADDRSIZE+1  entries readable, registered.
- runderflow  out  1  sticky underflow flag.

## Operation
- rbinnext = rbin + rpop, modulo 2^(ADDRSIZE+1).
- rgraynext = (rbinnext >> 1) ^ rbinnext.
- wbin = Gray-to-binary(rq2_wptr).
- lvlnext = wbin − rbinnext, modulo 2^(ADDRSIZE+1). No saturation is applied.
- Register updates each rclk:
  - rbin <= rbinnext
  - rptr <= rgraynext
  - rlevel <= lvlnext
  - rempty <= (rgraynext == rq2_wptr)
  - arempty <= (lvlnext <= rthresh), unsigned compare; this includes the empty case.
- raddr = rbin[ADDRSIZE-1:0].
- Pop while empty (rinc=1, rempty=1):
  - Ignored; no pointer movement and rpop=0.
  - runderflow sets and holds until reset (see Configuration).
- Wrap-around: the extra MSB disambiguates full from empty. rbin wraps 2^(ADDRSIZE+1)−1 → 0 with no special handling.
- Reset values:
  - rbin=0, rptr=0, raddr=0
  - rempty=1, arempty=1, rlevel=0
  - runderflow=0
- Reset dominates rinc in the same cycle.

## Timing
- Pop latency: an accepted pop in cycle N is reflected in raddr, rptr, rempty, arempty and rlevel at N+1.
- Write visibility: a change on rq2_wptr in cycle N is reflected in rempty, arempty and rlevel at N+1.
- Simultaneous pop and write-pointer advance in one cycle: both are applied, and rlevel is unchanged net.
- rempty is pessimistic: it deasserts only after the synchroniser delay; it never falsely deasserts.
- rthresh changes take effect on the next edge. It must not change while rinc is active if glitch-free arempty is required.
- No combinational path from rq2_wptr to any output.

## Configuration
- Macro: RPTR_EMPTY_LVL_UNDERFLOW_EN.
- Defined: runderflow sets on rinc & rempty and is sticky until rrst.
- Undefined: runderflow is tied 0 and the detection logic is not built.
- Pointer behaviour is identical either way.

## Structure
- Shared package async_fifo_pkg holds:
  - bin2gray and gray2bin functions, parameterised by width.
  - The pointer-width localparam convention, PTRW = ADDRSIZE+1.
- One sub-module, gray2bin, converts rq2_wptr using a WIDTH parameter. It is shared with the write-side full/level block.

## Test plan
1. **Reset.** Hold rrst=1 for 2 cycles with rinc=1 → rempty=1, arempty=1, rlevel=0, raddr=0, rptr=0, runderflow=0.
2. **Basic drain.** rq2_wptr=gray(3)=5'b00010, rthresh=1, rinc=0 → next cycle rempty=0, rlevel=3, arempty=0. Then pop 3 times:
   - after pop 2: rlevel=1, arempty=1
   - after pop 3: rempty=1, rlevel=0, raddr=3
3. **Underflow.** Set rinc=1 while empty → rpop=0 and raddr unchanged. runderflow=1 next cycle and stays 1 after rinc drops (macro defined); runderflow=0 always (macro undefined).
4. **Wrap.** Drive rbin to 15 and rq2_wptr to gray(17), giving rlevel=2. Pop twice:
   - first pop: raddr=0, rptr=gray(16)=5'b11000
   - second pop: rempty=1, rptr=gray(17)=5'b11001
5. **Simultaneous events.** At rlevel=2, pop while rq2_wptr advances by one → rlevel stays 2 and rempty stays 0.
6. **Reset mid-operation.** At rlevel=5 with rinc=1 and runderflow=1, assert rrst → next cycle all outputs are at reset values.
